// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential neuron MAC: FSM state encoding,
// default widths and a generic saturation helper.
package neuron_pkg;

    localparam int NEURON_DW   = 8;
    localparam int NEURON_FRAC = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        BIAS,
        SCALE,
        OUT
    } state_t;

    // Clamp a signed value (up to 64 bits) into the signed range of dw bits.
    function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] value,
                                                     input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/neuron_sat.sv
// Combinational arithmetic right shift by FRAC of an IW-bit signed value,
// saturated into DW signed bits.
module neuron_sat
    import neuron_pkg::*;
#(
    parameter int IW   = 27,
    parameter int DW   = 8,
    parameter int FRAC = 4
) (
    input  logic signed [IW-1:0] din,
    output logic signed [DW-1:0] dout
);

    logic signed [IW-1:0] r;

    assign r = din >>> FRAC;

    generate
        if (IW <= 64) begin : g_narrow
            logic signed [63:0] r64;
            logic signed [63:0] s64;
            assign r64  = 64'(r);
            assign s64  = sat_to_dw(r64, DW);
            assign dout = s64[DW-1:0];
        end else begin : g_wide
            // In range exactly when every bit above the DW-bit sign bit matches it.
            logic [IW-DW:0] top;
            assign top = r[IW-1:DW-1];
            always_comb begin
                if ((&top) || !(|top)) begin
                    dout = r[DW-1:0];
                end else if (r[IW-1]) begin
                    dout = {1'b1, {(DW-1){1'b0}}};
                end else begin
                    dout = {1'b0, {(DW-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/neuron_seq_mac.sv
// Serial N_IN-pair MAC neuron: accumulate x*w, add bias, scale by act (Q.FRAC),
// saturate to DW bits; y held until accepted. Define NEURON_SEQ_RELU_EN to clamp negative pre-activation sums to 0.
module neuron_seq_mac
    import neuron_pkg::*;
#(
    parameter int DW   = NEURON_DW,
    parameter int N_IN = 4,
    parameter int FRAC = NEURON_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] w,
    input  logic signed [DW-1:0] bias,
    input  logic signed [DW-1:0] act,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] y,
    output logic                 busy
);

    localparam int ACC_W = 2 * DW + $clog2(N_IN) + 1;
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int PW    = ACC_W + DW;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic signed [DW-1:0]    bias_q;
    logic signed [DW-1:0]    act_q;
    logic signed [DW-1:0]    y_q;

    logic signed [2*DW-1:0]  xw;
    logic signed [ACC_W-1:0] xw_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_bias;
    logic signed [PW-1:0]    scale_prod;
    logic signed [DW-1:0]    sat_y;

    assign xw       = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{w[DW-1]}}, w});
    assign xw_ext   = {{(ACC_W-2*DW){xw[2*DW-1]}}, xw};
    assign bias_ext = {{(ACC_W-DW){bias_q[DW-1]}}, bias_q};
    assign acc_sum  = acc + bias_ext;

`ifdef NEURON_SEQ_RELU_EN
    assign acc_bias = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
    assign acc_bias = acc_sum;
`endif

    // Both operands widened to PW so the product is exact; it cannot overflow PW.
    assign scale_prod = $signed({{DW{acc[ACC_W-1]}}, acc}) *
                        $signed({{ACC_W{act_q[DW-1]}}, act_q});

    neuron_sat #(
        .IW  (PW),
        .DW  (DW),
        .FRAC(FRAC)
    ) u_sat (
        .din (scale_prod),
        .dout(sat_y)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = (N_IN == 1) ? BIAS : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == CNT_W'(N_IN - 1))) begin
                    state_nxt = BIAS;
                end
            end
            BIAS: begin
                state_nxt = SCALE;
            end
            SCALE: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
            act_q  <= '0;
            y_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= xw_ext;
                        cnt    <= CNT_W'(1);
                        bias_q <= bias;
                        act_q  <= act;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= acc + xw_ext;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BIAS: begin
                    acc <= acc_bias;
                    cnt <= '0;
                end
                SCALE: begin
                    y_q <= sat_y;
                end
                default: begin
                end
            endcase
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Randomized self-checking bench for neuron_seq_mac (N_IN=3, DW=8, FRAC=4)
// against an arithmetic reference model of one group.
module tb_neuron_seq_mac;

    localparam int DW   = 8;
    localparam int N    = 3;
    localparam int FRAC = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] w;
    logic signed [DW-1:0] bias;
    logic signed [DW-1:0] act;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y;
    logic                 busy;

    int n_cmp;
    int n_fail;
    int cyc;

    neuron_seq_mac #(.DW(DW), .N_IN(N), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .bias     (bias),
        .act      (act),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: sum of products, plus bias, optional ReLU, times act, floor-shift, clamp.
    function automatic int model_y(input int xs[N], input int ws[N], input int b, input int a);
        longint s;
        longint p;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
        s += b;
`ifdef NEURON_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        p = s * a;
        p = p >>> FRAC;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return int'(p);
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one group; bias/act are scrambled after the first pair.
    task automatic send_group(input int xs[N], input int ws[N], input int b, input int a,
                              input bit gaps, output int last_acc);
        int n;
        last_acc = -1;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    x = DW'($urandom);
                    w = DW'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            x = DW'(xs[i]);
            w = DW'(ws[i]);
            if (i == 0) begin
                bias = DW'(b);
                act  = DW'(a);
            end else begin
                bias = DW'($urandom);
                act  = DW'($urandom);
            end
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_fail++;
                $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
            end
            last_acc = cyc;
            tick();
        end
        in_valid = 1'b0;
        x = DW'($urandom);
        w = DW'($urandom);
    endtask

    task automatic wait_out(output int oc, output bit ok);
        int n;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        ok = out_valid;
        oc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0; w = '0; bias = '0; act = '0;
        tick();
        tick();
        rst = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b need 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b need 0", out_valid); end
        n_cmp++; if (y !== 8'sd0) begin n_fail++; $display("FAIL reset_y: got %0d need 0", y); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b need 0", busy); end
    endtask

    task automatic test_nominal();
        int xs[N] = '{1, 2, 3};
        int ws[N] = '{4, 5, 6};
        int la, oc, exp_y;
        bit ok;
        exp_y = model_y(xs, ws, 2, 16);
        out_ready = 1'b1;
        send_group(xs, ws, 2, 16, 1'b0, la);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nominal_busy: got %0b need 1", busy); end
        wait_out(oc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL nominal_timeout: out_valid=%0b need 1", out_valid); end
        n_cmp++; if (y !== DW'(exp_y)) begin n_fail++; $display("FAIL nominal_y: got %0d need %0d", y, exp_y); end
        n_cmp++; if (oc - la !== 3) begin n_fail++; $display("FAIL nominal_latency: got %0d need 3", oc - la); end
        tick();
    endtask

    task automatic test_saturation();
        int xs[N];
        int ws[N];
        int la, oc, exp_y;
        bit ok;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = (k == 0) ? 127 : -128;
                ws[i] = 127;
            end
            exp_y = model_y(xs, ws, 0, 16);
            send_group(xs, ws, 0, 16, 1'b0, la);
            wait_out(oc, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL sat_timeout[%0d]: out_valid=%0b need 1", k, out_valid); end
            n_cmp++; if (y !== DW'(exp_y)) begin n_fail++; $display("FAIL sat_y[%0d]: got %0d need %0d", k, y, exp_y); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int xs[N] = '{1, 2, 3};
        int ws[N] = '{4, 5, 6};
        int la, oc, exp_y;
        bit ok;
        exp_y = model_y(xs, ws, 2, 16);
        out_ready = 1'b0;
        send_group(xs, ws, 2, 16, 1'b0, la);
        wait_out(oc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: out_valid=%0b need 1", out_valid); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || y !== DW'(exp_y) || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%0b y=%0d in_ready=%0b need 1/%0d/0",
                         k, out_valid, y, in_ready, exp_y);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b busy=%0b need 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int xs[N] = '{1, 2, 3};
        int ws[N] = '{4, 5, 6};
        int la, oc, exp_y;
        bit ok;
        bit saw;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            x = DW'(rnd8());
            w = DW'(rnd8());
            bias = DW'(rnd8());
            act = DW'(rnd8());
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) saw = 1'b1;
            tick();
        end
        n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_spurious: out_valid seen=%0b need 0", saw); end
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: in_ready=%0b busy=%0b need 1/0", in_ready, busy); end
        exp_y = model_y(xs, ws, 2, 16);
        send_group(xs, ws, 2, 16, 1'b0, la);
        wait_out(oc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: out_valid=%0b need 1", out_valid); end
        n_cmp++; if (y !== DW'(exp_y)) begin n_fail++; $display("FAIL rstmid_y: got %0d need %0d", y, exp_y); end
        tick();
    endtask

    task automatic test_relu();
        int xs[N] = '{-1, -2, -3};
        int ws[N] = '{4, 5, 6};
        int la, oc, exp_y;
        bit ok;
        out_ready = 1'b1;
        exp_y = model_y(xs, ws, 0, 16);
        send_group(xs, ws, 0, 16, 1'b0, la);
        wait_out(oc, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL relu_timeout: out_valid=%0b need 1", out_valid); end
        n_cmp++; if (y !== DW'(exp_y)) begin n_fail++; $display("FAIL relu_y: got %0d need %0d", y, exp_y); end
        tick();
    endtask

    task automatic test_gaps();
        int xs[N];
        int ws[N];
        int b, a, la, oc, exp_y;
        bit ok;
        out_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = rnd8();
                ws[i] = rnd8();
            end
            b = rnd8();
            a = (it < 8) ? int'($urandom_range(0, 64)) : rnd8();
            exp_y = model_y(xs, ws, b, a);
            send_group(xs, ws, b, a, 1'b1, la);
            wait_out(oc, ok);
            n_cmp++;
            if (!ok || y !== DW'(exp_y) || oc - la !== 3) begin
                n_fail++;
                $display("FAIL gaps[%0d]: ok=%0b y=%0d lat=%0d need y=%0d lat=3", it, ok, y, oc - la, exp_y);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int xs[N];
        int ws[N];
        int b, a, la, oc1, oc2, exp_y;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            xs[i] = rnd8();
            ws[i] = rnd8();
        end
        b = rnd8();
        a = rnd8();
        exp_y = model_y(xs, ws, b, a);
        send_group(xs, ws, b, a, 1'b0, la);
        wait_out(oc1, ok);
        n_cmp++; if (!ok || y !== DW'(exp_y)) begin n_fail++; $display("FAIL b2b_first: ok=%0b y=%0d need %0d", ok, y, exp_y); end
        for (int i = 0; i < N; i++) begin
            xs[i] = rnd8();
            ws[i] = rnd8();
        end
        b = rnd8();
        a = rnd8();
        exp_y = model_y(xs, ws, b, a);
        send_group(xs, ws, b, a, 1'b0, la);
        wait_out(oc2, ok);
        n_cmp++; if (!ok || y !== DW'(exp_y)) begin n_fail++; $display("FAIL b2b_second: ok=%0b y=%0d need %0d", ok, y, exp_y); end
        n_cmp++; if (oc2 - oc1 !== N + 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d need %0d", oc2 - oc1, N + 3); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_nominal();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_relu();
        test_gaps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

endmodule
